// File: rtl/tone_counter.sv
// tone_counter: keypad note/octave -> per-period count/divisor for the waveshaper (clk, Rst_i, key_i, octave_i -> count, divisor, wrap_o, active_o)
module tone_counter #(
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             Rst_i,
  input  logic [3:0]       key_i,
  input  logic [2:0]       octave_i,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] divisor,
  output logic             wrap_o,
  output logic             active_o
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [15:0] base;
  logic [CNT_W-1:0] div, count_nx, divisor_nx;
  logic key_ok, boundary, reload, wrap_nx;
  always_comb begin
    case (key_i)
      4'd1:    base = 16'd45867;
      4'd2:    base = 16'd43293;
      4'd3:    base = 16'd40863;
      4'd4:    base = 16'd38569;
      4'd5:    base = 16'd36405;
      4'd6:    base = 16'd34361;
      4'd7:    base = 16'd32432;
      4'd8:    base = 16'd30613;
      4'd9:    base = 16'd28894;
      4'd10:   base = 16'd27273;
      4'd11:   base = 16'd25742;
      4'd12:   base = 16'd24297;
      default: base = 16'd0;
    endcase
  end
  assign key_ok   = base != 16'd0;
  assign div      = CNT_W'({base, 3'b000}) >> octave_i;
  assign boundary = count == divisor - 1'b1;
  assign reload   = state == IDLE || boundary;
  assign active_o = state == RUN;
  always_comb begin
    state_nx   = reload ? (key_ok ? RUN : IDLE) : state;
    count_nx   = reload ? '0 : count + 1'b1;
    divisor_nx = reload ? (key_ok ? div : '0) : divisor;
    wrap_nx    = state == RUN && boundary;
  end
  always_ff @(posedge clk or negedge Rst_i) begin
    if (!Rst_i) begin
      state   <= IDLE;
      count   <= '0;
      divisor <= '0;
      wrap_o  <= 1'b0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      divisor <= divisor_nx;
      wrap_o  <= wrap_nx;
    end
  end
endmodule

// File: tb/tb_tone_counter.sv
// tb_tone_counter: randomized scoreboard bench for tone_counter
module tb_tone_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] key_i = '0;
  logic [2:0] octave_i = '0;
  logic [18:0] count, divisor;
  logic wrap_o, active_o;
  tone_counter #(.CNT_W(19)) dut (
    .clk(clk), .Rst_i(rst_n), .key_i(key_i), .octave_i(octave_i),
    .count(count), .divisor(divisor), .wrap_o(wrap_o), .active_o(active_o)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int wcyc; int div; bit act;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int bnd = 0, cur_div = 0;
  bit running = 0;
  int base_tab[13] = '{0, 45867, 43293, 40863, 38569, 36405, 34361, 32432, 30613, 28894, 27273, 25742, 24297};
  function automatic int ref_div(int k, int o);
    if (k < 1 || k > 12) return 0;
    return (base_tab[k] * 8) / (1 << o);
  endfunction
  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (wrap_o) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_wrap: got wrap at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wrap_cycle", cyc, e.wcyc);
        chk("wrap_divisor", divisor, e.div);
        chk("wrap_count", count, 0);
        chk("wrap_active", active_o, e.act);
      end
    end
  end
  task automatic start(int k, int o);
    key_i = 4'(k);
    octave_i = 3'(o);
    cur_div = ref_div(k, o);
    bnd = cyc + 1 + cur_div;
    running = 1;
    @(negedge clk);
    chk("start_divisor", divisor, cur_div);
    chk("start_count", count, 0);
    chk("start_active", active_o, 1);
  endtask
  task automatic next_period(int k, int o, bit junk);
    chk("probe_count", count, cyc - (bnd - cur_div));
    while (cyc < bnd - 1) begin
      if (junk) begin
        key_i = 4'($urandom);
        octave_i = 3'($urandom);
      end
      @(negedge clk);
    end
    key_i = 4'(k);
    octave_i = 3'(o);
    cur_div = ref_div(k, o);
    q.push_back('{bnd, cur_div, cur_div != 0});
    if (cur_div != 0) bnd += cur_div;
    else running = 0;
    @(negedge clk);
  endtask
  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_divisor", divisor, 0);
    chk("rst_wrap", wrap_o, 0);
    chk("rst_active", active_o, 0);
    q.delete();
    running = 0;
    key_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      key_i = 4'($urandom);
      octave_i = 3'($urandom);
      chk("hold_count", count, 0);
      chk("hold_divisor", divisor, 0);
      chk("hold_wrap", wrap_o, 0);
      chk("hold_active", active_o, 0);
    end
    key_i = '0;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_divisor", divisor, 0);
      chk("idle_active", active_o, 0);
    end
    start(10, 3);
    while (cyc < bnd - cur_div + 1000) @(negedge clk);
    key_i = 4'd1;
    octave_i = 3'd1;
    next_period(1, 1, 0);
    repeat (20) @(negedge clk);
    chk("run_count", count, cyc - (bnd - cur_div));
    chk("run_divisor", divisor, 183468);
    mid_reset();
    start(12, 7);
    repeat (50) @(negedge clk);
    key_i = '0;
    next_period(0, 0, 0);
    key_i = 4'd14;
    repeat (3) begin
      @(negedge clk);
      chk("off_divisor", divisor, 0);
      chk("off_count", count, 0);
      chk("off_active", active_o, 0);
    end
    start(12, 7);
    repeat (3) next_period(12, 7, 1);
    next_period(1, 0, 0);
    repeat (10) @(negedge clk);
    chk("low_divisor", divisor, 366936);
    chk("low_count", count, cyc - (bnd - cur_div));
    mid_reset();
    start(10, 7);
    next_period(5, 7, 1);
    next_period(0, 0, 1);
    for (int i = 0; i < 15; i++) begin
      if (!running) begin
        key_i = '0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        start($urandom_range(1, 12), 7);
      end
      next_period($urandom_range(0, 15), 7, 1);
    end
    if (running) next_period(0, 0, 1);
    repeat (3) @(negedge clk);
    chk("final_active", active_o, 0);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
